// File: rtl/priority_encoder_8to3_hs.sv
// 8-to-3 priority encoder with change detection and a valid/ready output handshake.
// Define PRIORITY_ENCODER_SYNC_EN to pass x through a two-flop synchronizer before encoding.
module priority_encoder_8to3_hs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] x,
  input  logic       code_ready,
  output logic [2:0] code_out,
  output logic       code_valid,
  output logic       any,
  output logic [3:0] drop_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic [2:0] enc_msb(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [7:0] xs;

`ifdef PRIORITY_ENCODER_SYNC_EN
  logic [7:0] sync_p0, sync_p1;

  // Stage p0/p1: two-flop synchronizer, two cycles from x to xs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= x;
      sync_p1 <= sync_p0;
    end
  end

  assign xs = sync_p1;
`else
  assign xs = x;
`endif

  logic [2:0] cur_code;
  logic       cur_any;
  logic [2:0] last_code;
  logic       last_any;
  logic       evt;
  state_t     state;

  // An event is a new or changed highest-priority request; lower bits alone never retrigger.
  assign cur_code = enc_msb(xs);
  assign cur_any  = |xs;
  assign evt      = en & cur_any & (~last_any | (cur_code != last_code));

  // Registered stage: change-detect history, handshake FSM and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_out   <= 3'd0;
      code_valid <= 1'b0;
      any        <= 1'b0;
      drop_cnt   <= 4'd0;
      last_code  <= 3'd0;
      last_any   <= 1'b0;
    end else begin
      any <= en & cur_any;
      if (en) begin
        last_code <= cur_code;
        last_any  <= cur_any;
      end else begin
        last_any  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (evt) begin
            code_out   <= cur_code;
            code_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (code_ready) begin
            if (evt) begin
              code_out <= cur_code;
            end else begin
              code_valid <= 1'b0;
              state      <= IDLE;
            end
          end else if (evt) begin
            // Consumer stalled: the pending code wins, the new one is counted as lost
            drop_cnt <= sat_inc(drop_cnt);
          end
        end
        default: begin
          code_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
